// File: rtl/ps2_buffered_receiver_if.sv
// Receive-side bus of the PS/2 receiver: ready/valid byte stream plus status and error reporting.
interface ps2_buffered_receiver_if #(
  parameter int unsigned FIFO_ADDR_WIDTH = 4
);
  logic                       rxValid;
  logic [7:0]                 rxData;
  logic                       rxReady;
  logic [FIFO_ADDR_WIDTH:0]   fifoCount;
  logic                       overflow;
  logic                       clearOverflow;
  logic                       errorPulse;
  logic [1:0]                 errorCode;

  modport master (
    output rxValid, rxData, fifoCount, overflow, errorPulse, errorCode,
    input  rxReady, clearOverflow
  );

  modport slave (
    input  rxValid, rxData, fifoCount, overflow, errorPulse, errorCode,
    output rxReady, clearOverflow
  );
endinterface

// File: rtl/ps2_buffered_receiver.sv
// PS/2 device-to-host receiver: synchronise, debounce, frame 11-bit words, queue good bytes in a FWFT FIFO.
module ps2_buffered_receiver #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 15,
  parameter int unsigned WATCHDOG_CYCLES = 5120,
  parameter int unsigned FIFO_ADDR_WIDTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ps2Clock,
  input  logic                    ps2Data,
  ps2_buffered_receiver_if.master rx
);
  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned WD_W  = $clog2(WATCHDOG_CYCLES + 1);
  localparam int unsigned DEPTH = 1 << FIFO_ADDR_WIDTH;
  localparam int unsigned CNT_W = FIFO_ADDR_WIDTH + 1;

  localparam logic [1:0] ERR_TIMEOUT = 2'b00;
  localparam logic [1:0] ERR_START   = 2'b01;
  localparam logic [1:0] ERR_PARITY  = 2'b10;
  localparam logic [1:0] ERR_STOP    = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_PARITY, S_STOP, S_ERROR} state_t;

  logic [SYNC_STAGES-1:0]   clk_sync, data_sync;
  logic [1:0]               sync_line, deb;
  logic [1:0][DB_W-1:0]     db_cnt;
  logic                     deb_clk_d;
  logic                     fall_c, edge_c, expired_c;
  logic [WD_W-1:0]          wd;
  state_t                   state;
  logic [2:0]               bit_cnt;
  logic                     parity;
  logic [7:0]               shift;
  logic                     error_pulse;
  logic [1:0]               error_code;
  logic                     push_c, pop_c, full_c, wr_en_c, ovf_evt_c;
  logic [7:0]               mem [DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]         count, count_next_c;
  logic                     valid_q, overflow_q;

  // Two-line synchroniser; idle level of both PS/2 lines is high
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2Clock};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2Data};
    end
  end

  assign sync_line = {data_sync[SYNC_STAGES-1], clk_sync[SYNC_STAGES-1]};

  // Index 0 = clock line, index 1 = data line
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      deb    <= 2'b11;
      db_cnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_line[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          deb[i]    <= sync_line[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign fall_c    = deb_clk_d & ~deb[0];
  assign edge_c    = deb_clk_d ^ deb[0];
  assign expired_c = (wd == WD_W'(WATCHDOG_CYCLES));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      deb_clk_d <= 1'b1;
      wd        <= '0;
    end else begin
      deb_clk_d <= deb[0];
      if (edge_c)         wd <= '0;
      else if (!expired_c) wd <= wd + WD_W'(1);
    end
  end

  // Frame decoder; timeout only aborts a frame already in progress
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      bit_cnt     <= '0;
      parity      <= 1'b0;
      shift       <= '0;
      error_pulse <= 1'b0;
      error_code  <= ERR_TIMEOUT;
    end else begin
      error_pulse <= 1'b0;
      if ((state == S_DATA || state == S_PARITY || state == S_STOP) && !fall_c && expired_c) begin
        state       <= S_ERROR;
        error_pulse <= 1'b1;
        error_code  <= ERR_TIMEOUT;
      end else begin
        case (state)
          S_IDLE: if (fall_c) begin
            if (!deb[1]) begin
              state   <= S_DATA;
              bit_cnt <= '0;
              parity  <= 1'b0;
            end else begin
              state       <= S_ERROR;
              error_pulse <= 1'b1;
              error_code  <= ERR_START;
            end
          end
          S_DATA: if (fall_c) begin
            shift   <= {deb[1], shift[7:1]};
            parity  <= parity ^ deb[1];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= S_PARITY;
          end
          S_PARITY: if (fall_c) begin
            if (parity ^ deb[1]) begin
              state <= S_STOP;
            end else begin
              state       <= S_ERROR;
              error_pulse <= 1'b1;
              error_code  <= ERR_PARITY;
            end
          end
          S_STOP: if (fall_c) begin
            if (deb[1]) begin
              state <= S_IDLE;
            end else begin
              state       <= S_ERROR;
              error_pulse <= 1'b1;
              error_code  <= ERR_STOP;
            end
          end
          S_ERROR: if (expired_c && deb[0] && deb[1]) state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // FIFO control; a push into a full FIFO survives only when a pop frees a slot the same cycle
  assign push_c       = (state == S_STOP) && fall_c && deb[1];
  assign pop_c        = valid_q & rx.rxReady;
  assign full_c       = (count == CNT_W'(DEPTH));
  assign wr_en_c      = push_c & (~full_c | pop_c);
  assign ovf_evt_c    = push_c & full_c & ~pop_c;
  assign count_next_c = count + CNT_W'(wr_en_c) - CNT_W'(pop_c);

  always_ff @(posedge clock) begin
    if (wr_en_c) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en_c) wr_ptr <= wr_ptr + FIFO_ADDR_WIDTH'(1);
      if (pop_c)   rd_ptr <= rd_ptr + FIFO_ADDR_WIDTH'(1);
      count   <= count_next_c;
      valid_q <= (count_next_c != '0);
      if (ovf_evt_c)             overflow_q <= 1'b1;
      else if (rx.clearOverflow) overflow_q <= 1'b0;
    end
  end

  assign rx.rxValid    = valid_q;
  assign rx.rxData     = mem[rd_ptr];
  assign rx.fifoCount  = count;
  assign rx.overflow   = overflow_q;
  assign rx.errorPulse = error_pulse;
  assign rx.errorCode  = error_code;
endmodule

// File: tb/tb_ps2_buffered_receiver.sv
// Bench for ps2_buffered_receiver: PS/2 frame generator, byte-queue reference model, error-code scoreboard.
`timescale 1ns/1ps
module tb_ps2_buffered_receiver;
  localparam int unsigned FAW   = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned SYNC  = 2;
  localparam int unsigned DEB   = 15;
  localparam int unsigned WD    = 5120;
  localparam int          HALF  = 40;

  logic clock    = 1'b0;
  logic reset    = 1'b0;
  logic ps2Clock = 1'b1;
  logic ps2Data  = 1'b1;

  ps2_buffered_receiver_if #(.FIFO_ADDR_WIDTH(FAW)) rx ();

  ps2_buffered_receiver #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .WATCHDOG_CYCLES(WD), .FIFO_ADDR_WIDTH(FAW)
  ) dut (
    .clock(clock), .reset(reset), .ps2Clock(ps2Clock), .ps2Data(ps2Data), .rx(rx)
  );

  always #5 clock = ~clock;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q [$];
  logic [1:0] exp_err_q [$];
  logic [1:0] err_q [$];
  bit         exp_ovf = 1'b0;
  bit         rand_ready = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Consumer side: every accepted byte must be the oldest one the model expects
  always @(negedge clock) begin
    #2;
    if (reset) begin
      if (rx.errorPulse) err_q.push_back(rx.errorCode);
      if (rx.rxValid && rx.rxReady) begin
        check("pop_has_data", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("pop_data", 32'(rx.rxData), 32'(exp_q.pop_front()));
      end
    end
  end

  always @(negedge clock) begin
    if (rand_ready) rx.rxReady = 1'($urandom_range(0, 1));
  end

  // kind: 0 good, 1 bad parity, 2 bad stop, 3 bad start; nbits < 11 truncates the frame
  task automatic send_frame(input logic [7:0] d, input int kind, input int nbits, input bit pop_at_stop);
    logic [10:0] bits;
    bits = {1'b1, ~(^d), d, 1'b0};
    if (kind == 1) bits[9]  = ~bits[9];
    if (kind == 2) bits[10] = 1'b0;
    if (kind == 3) bits[0]  = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      if (i == 10 && kind == 0) begin
        if (exp_q.size() < DEPTH || pop_at_stop) exp_q.push_back(d);
        else exp_ovf = 1'b1;
      end
      ps2Data = bits[i];
      tick(HALF / 2);
      ps2Clock = 1'b0;
      if (i == 10 && pop_at_stop) begin
        tick(SYNC + DEB);
        rx.rxReady = 1'b1;
        tick(1);
        rx.rxReady = 1'b0;
        tick(HALF - SYNC - DEB - 1);
      end else begin
        tick(HALF);
      end
      ps2Clock = 1'b1;
      tick(HALF / 2);
    end
    ps2Data = 1'b1;
    if (nbits == 11) begin
      if (kind == 1) exp_err_q.push_back(2'b10);
      if (kind == 2) exp_err_q.push_back(2'b11);
      if (kind == 3) exp_err_q.push_back(2'b01);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_count"}, 32'(rx.fifoCount), 32'(exp_q.size()));
    check({tag, "_valid"}, 32'(rx.rxValid), 32'(exp_q.size() != 0));
    check({tag, "_ovf"}, 32'(rx.overflow), 32'(exp_ovf));
    if (exp_q.size() != 0) check({tag, "_data"}, 32'(rx.rxData), 32'(exp_q[0]));
  endtask

  task automatic check_errors(input string tag);
    check({tag, "_nerr"}, 32'(err_q.size()), 32'(exp_err_q.size()));
    for (int i = 0; i < exp_err_q.size() && i < err_q.size(); i++)
      check({tag, "_code"}, 32'(err_q[i]), 32'(exp_err_q[i]));
    err_q.delete();
    exp_err_q.delete();
  endtask

  task automatic drain(input string tag);
    rx.rxReady = 1'b1;
    tick(DEPTH + 4);
    rx.rxReady = 1'b0;
    tick(1);
    check_state(tag);
  endtask

  initial begin
    int kind;
    logic [7:0] d;
    rx.rxReady       = 1'b0;
    rx.clearOverflow = 1'b0;
    tick(3);
    check("rst_valid", 32'(rx.rxValid), 32'd0);
    check("rst_count", 32'(rx.fifoCount), 32'd0);
    check("rst_ovf", 32'(rx.overflow), 32'd0);
    check("rst_pulse", 32'(rx.errorPulse), 32'd0);
    check("rst_code", 32'(rx.errorCode), 32'd0);
    reset = 1'b1;
    tick(50);

    // Single good frame
    send_frame(8'h1C, 0, 11, 1'b0);
    tick(HALF);
    check("t1_data_abs", 32'(rx.rxData), 32'h1C);
    check("t1_count_abs", 32'(rx.fifoCount), 32'd1);
    check_state("t1");
    check_errors("t1");
    drain("t1_drain");

    // Parity error, recovery, then good frame
    send_frame(8'h1C, 1, 11, 1'b0);
    tick(HALF);
    check_errors("t2_err");
    check_state("t2_err");
    tick(WD + 100);
    send_frame(8'hF0, 0, 11, 1'b0);
    tick(HALF);
    check_state("t2_good");
    check_errors("t2_good");
    drain("t2_drain");

    // Clock stops mid-frame: timeout only after the full watchdog interval
    send_frame(8'h5A, 0, 5, 1'b0);
    tick(WD - 200);
    check("t3_early", 32'(err_q.size()), 32'd0);
    tick(300);
    exp_err_q.push_back(2'b00);
    check_errors("t3_timeout");
    check_state("t3_timeout");
    send_frame(8'hA5, 0, 11, 1'b0);
    tick(HALF);
    check_state("t3_good");
    check_errors("t3_good");
    drain("t3_drain");

    // Fill past depth with no consumer
    for (int i = 0; i <= 16; i++) send_frame(8'(i), 0, 11, 1'b0);
    tick(HALF);
    check("t4_count_abs", 32'(rx.fifoCount), 32'd16);
    check("t4_ovf_abs", 32'(rx.overflow), 32'd1);
    check_state("t4_full");
    check_errors("t4");
    rx.clearOverflow = 1'b1;
    tick(1);
    rx.clearOverflow = 1'b0;
    exp_ovf = 1'b0;
    check_state("t4_clr");

    // Full FIFO: pop coincides with the stop-bit push
    send_frame(8'h11, 0, 11, 1'b1);
    tick(HALF);
    check("t5_count_abs", 32'(rx.fifoCount), 32'd16);
    check_state("t5");
    drain("t5_drain");

    // Short clock glitch must be filtered out
    ps2Clock = 1'b0;
    tick(10);
    ps2Clock = 1'b1;
    tick(60);
    check_errors("t6_glitch");
    check_state("t6_glitch");

    // Leave a byte queued and an error code set, then reset mid-frame
    send_frame(8'h3C, 0, 11, 1'b0);
    send_frame(8'h77, 2, 11, 1'b0);
    tick(HALF);
    check_errors("t6_stop");
    check_state("t6_pre");
    send_frame(8'h99, 0, 4, 1'b0);
    reset = 1'b0;
    #1;
    check("t6_rst_valid", 32'(rx.rxValid), 32'd0);
    check("t6_rst_count", 32'(rx.fifoCount), 32'd0);
    check("t6_rst_pulse", 32'(rx.errorPulse), 32'd0);
    check("t6_rst_code", 32'(rx.errorCode), 32'd0);
    exp_q.delete();
    err_q.delete();
    exp_err_q.delete();
    exp_ovf = 1'b0;
    tick(5);
    reset = 1'b1;
    tick(50);
    send_frame(8'hC3, 0, 11, 1'b0);
    tick(HALF);
    check_state("t6_after");
    check_errors("t6_after");

    // Random frames with a randomly stalling consumer
    rand_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      kind = int'($urandom_range(0, 7));
      kind = (kind < 4) ? 0 : kind - 4;
      d = 8'($urandom);
      send_frame(d, kind, 11, 1'b0);
      tick(HALF);
      check_errors("rnd");
      if (kind != 0) tick(WD + 100);
    end
    rand_ready = 1'b0;
    rx.rxReady = 1'b0;
    tick(2);
    check_state("rnd_end");
    drain("rnd_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
